// File: rtl/serdes_lane_fifo_pkg.sv
// Shared types and helpers for the FIFO-buffered multi-lane serdes loopback.
package serdes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } serdes_state_e;

   function automatic int beats_f(input int dw, input int lanes);
      return dw / lanes;
   endfunction

endpackage

// File: rtl/serdes_lane_fifo_if.sv
// Parallel in/out handshakes, serial observation port and FIFO status of one lane group.
interface serdes_lane_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 1,
   parameter int FIFO_DEPTH = 16
);
   logic [DATA_WIDTH-1:0]         parallel_in_i;
   logic                          valid_in_i;
   logic                          ready_out_o;
   logic [DATA_WIDTH-1:0]         parallel_out_o;
   logic                          valid_out_o;
   logic                          ready_in_i;
   logic [LANES-1:0]              serial_o;
   logic                          serial_valid_o;
   logic                          fifo_full_o;
   logic                          fifo_empty_o;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;

   modport slave (
      input  parallel_in_i, valid_in_i, ready_in_i,
      output ready_out_o, parallel_out_o, valid_out_o, serial_o, serial_valid_o,
             fifo_full_o, fifo_empty_o, fifo_level_o
   );

   modport master (
      output parallel_in_i, valid_in_i, ready_in_i,
      input  ready_out_o, parallel_out_o, valid_out_o, serial_o, serial_valid_o,
             fifo_full_o, fifo_empty_o, fifo_level_o
   );
endinterface

// File: rtl/serdes_lane_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pushed word is readable from the next cycle.
module serdes_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic                      pop_i,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_push;
   logic                  w_pop;

   assign full_o  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign level_o = r_wr_ptr - r_rd_ptr;
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: the pointers define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/serdes_lane_fifo.sv
// FIFO-buffered serialiser (LANES bits per beat) looped into a deserialiser with a
// valid/ready output register.
//   state | meaning
//   IDLE  | no word in flight, waiting for the FIFO to hold one
//   SHIFT | one beat on serial_o per cycle, deserialiser capturing it
//   HOLD  | word reassembled, waiting for the output register to free up
module serdes_lane_fifo
   import serdes_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 1,
   parameter int FIFO_DEPTH = 16,
   parameter bit MSB_FIRST  = 1'b1
) (
   input logic               clk_i,
   input logic               rst_i,
   serdes_lane_fifo_if.slave bus
);
   localparam int BEATS = beats_f(DATA_WIDTH, LANES);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

   if ((DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
      $error("serdes_lane_fifo: DATA_WIDTH must be a multiple of LANES");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("serdes_lane_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end

   serdes_state_e         r_state;
   serdes_state_e         w_next;
   logic [BW-1:0]         r_beat;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_deshift;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_vout;
   logic [DATA_WIDTH-1:0] w_fifo_rdata;
   logic [DATA_WIDTH-1:0] w_assembled;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [LANES-1:0]      w_beat_bits;
   logic                  w_pop;
   logic                  w_load;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_last;
   logic                  w_out_free;
   logic [LW-1:0]         w_level;

   serdes_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .wdata_i (bus.parallel_in_i),
      .pop_i   (w_pop),
      .rdata_o (w_fifo_rdata),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (w_level)
   );

   // Acceptance ignores a same-cycle pop so ready_out_o stays purely registered state.
   assign bus.ready_out_o  = !w_full && !rst_i;
   assign w_push           = bus.valid_in_i && bus.ready_out_o;
   assign bus.fifo_full_o  = w_full;
   assign bus.fifo_empty_o = w_empty;
   assign bus.fifo_level_o = w_level;

   assign w_beat_bits  = MSB_FIRST ? r_shift[DATA_WIDTH-1 -: LANES] : r_shift[LANES-1:0];
   assign w_shift_next = MSB_FIRST ? (r_shift << LANES) : (r_shift >> LANES);
   assign w_last       = (r_beat == BEAT_LAST);
   assign w_out_free   = !r_vout || bus.ready_in_i;

   assign bus.serial_valid_o = (r_state == SHIFT);
   assign bus.serial_o       = (r_state == SHIFT) ? w_beat_bits : '0;
   assign bus.valid_out_o    = r_vout;
   assign bus.parallel_out_o = r_out;

   // Word as it stands after folding in the current beat; complete on the last beat.
   if (BEATS == 1) begin : g_asm_one
      assign w_assembled = w_beat_bits;
   end else if (MSB_FIRST) begin : g_asm_msb
      assign w_assembled = {r_deshift[DATA_WIDTH-LANES-1:0], w_beat_bits};
   end else begin : g_asm_lsb
      assign w_assembled = {w_beat_bits, r_deshift[DATA_WIDTH-1:LANES]};
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last) begin
               if (w_out_free) begin
                  w_load = 1'b1;
                  w_pop  = !w_empty;
                  w_next = w_empty ? IDLE : SHIFT;
               end else begin
                  w_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_out_free) begin
               w_load = 1'b1;
               w_pop  = !w_empty;
               w_next = w_empty ? IDLE : SHIFT;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_shift   <= '0;
         r_deshift <= '0;
         r_out     <= '0;
         r_vout    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_shift <= w_fifo_rdata;
            r_beat  <= '0;
         end else if (r_state == SHIFT) begin
            r_shift <= w_shift_next;
            r_beat  <= w_last ? '0 : r_beat + BEAT_ONE;
         end
         if (r_state == SHIFT) r_deshift <= w_assembled;
         // In HOLD the finished word already sits in r_deshift.
         if (w_load) begin
            r_out  <= (r_state == SHIFT) ? w_assembled : r_deshift;
            r_vout <= 1'b1;
         end else if (bus.ready_in_i) begin
            r_vout <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_serdes_lane_fifo.sv
// Directed bench for serdes_lane_fifo: single-lane timing/fill/reset sequence plus
// a random multi-lane sweep on extra instances.
module tb_serdes_lane_fifo;
   localparam int NSW      = 5;
   localparam int NW       = 1000;
   localparam int SW_LIMIT = 20000;

   logic clk = 1'b0;
   logic rst;
   bit   sweep_go = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;

   int   sw_bad   [NSW];
   int   sw_rcv   [NSW];
   int   sw_srcv  [NSW];
   int   sw_beats [NSW];
   bit   sw_done  [NSW];

   always #5 clk = ~clk;

   serdes_lane_fifo_if #(.DATA_WIDTH(8), .LANES(1), .FIFO_DEPTH(16)) bus ();

   serdes_lane_fifo #(
      .DATA_WIDTH (8),
      .LANES      (1),
      .FIFO_DEPTH (16),
      .MSB_FIRST  (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   function automatic int lanes_of(input int i);
      return (i < 2) ? 2 : ((i < 4) ? 4 : 8);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < NSW; g++) begin : g_sw
      localparam int L = lanes_of(g);
      localparam bit M = (g == 4) ? 1'b1 : ((g % 2) == 1);
      localparam int B = 8 / L;

      serdes_lane_fifo_if #(.DATA_WIDTH(8), .LANES(L), .FIFO_DEPTH(8)) sbus ();

      serdes_lane_fifo #(
         .DATA_WIDTH (8),
         .LANES      (L),
         .FIFO_DEPTH (8),
         .MSB_FIRST  (M)
      ) u_dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (sbus.slave)
      );

      logic [7:0] words [NW];
      logic [7:0] acc;
      int sent  = 0;
      int rcv   = 0;
      int srcv  = 0;
      int nb    = 0;
      int bad   = 0;
      int beats = 0;
      bit done  = 1'b0;
      bit pend;

      assign sw_bad[g]   = bad;
      assign sw_rcv[g]   = rcv;
      assign sw_srcv[g]  = srcv;
      assign sw_beats[g] = beats;
      assign sw_done[g]  = done;

      initial begin
         sbus.valid_in_i    = 1'b0;
         sbus.ready_in_i    = 1'b0;
         sbus.parallel_in_i = '0;
         for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
         wait (sweep_go);
         @(posedge clk); #1;
         for (int c = 0; c < SW_LIMIT && !(sent == NW && rcv == NW); c++) begin
            sbus.valid_in_i    = (sent < NW);
            sbus.parallel_in_i = words[(sent < NW) ? sent : 0];
            sbus.ready_in_i    = ($urandom_range(0, 3) != 0);
            pend = sbus.valid_in_i && sbus.ready_out_o;
            @(posedge clk); #1;
            if (pend) sent++;
         end
         sbus.valid_in_i = 1'b0;
         sbus.ready_in_i = 1'b0;
         done = 1'b1;
      end

      // Reference packing of observed beats, independent of the DUT deserialiser.
      always @(negedge clk) begin
         if (sbus.valid_out_o && sbus.ready_in_i && rcv < NW) begin
            if (sbus.parallel_out_o !== words[rcv]) bad++;
            rcv++;
         end
         if (sbus.serial_valid_o === 1'b1) begin
            beats++;
            if (M) acc = (acc << L) | 8'(sbus.serial_o);
            else   acc = (acc >> L) | (8'(sbus.serial_o) << (8 - L));
            nb++;
            if (nb == B) begin
               nb = 0;
               if (srcv < NW) begin
                  if (acc !== words[srcv]) bad++;
                  srcv++;
               end
            end
         end
      end
   end

   initial begin
      int         n;
      int         cyc;
      int         exp_idx;
      int         cnt;
      bit         acc_now;
      bit         all_done;
      logic [7:0] pat;

      rst = 1'b1;
      bus.valid_in_i    = 1'b0;
      bus.parallel_in_i = '0;
      bus.ready_in_i    = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", bus.ready_out_o, 0);
      end
      chk("rst_vout", bus.valid_out_o, 0);
      chk("rst_empty", bus.fifo_empty_o, 1);
      chk("rst_sv", bus.serial_valid_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", bus.ready_out_o, 1);
      chk("post_rst_empty", bus.fifo_empty_o, 1);
      chk("post_rst_level", bus.fifo_level_o, 0);
      chk("post_rst_vout", bus.valid_out_o, 0);
      chk("post_rst_full", bus.fifo_full_o, 0);

      // Single word 0xA5, MSB first, latency
      pat = 8'hA5;
      @(posedge clk); #1;
      bus.parallel_in_i = pat;
      bus.valid_in_i    = 1'b1;
      @(posedge clk); #1;
      bus.valid_in_i = 1'b0;
      @(negedge clk);
      chk("t2_sv_before", bus.serial_valid_o, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_sv", bus.serial_valid_o, 1);
         chk("t2_bit", bus.serial_o, pat[7-i]);
         chk("t2_vout_early", bus.valid_out_o, 0);
      end
      @(negedge clk);
      chk("t2_vout", bus.valid_out_o, 1);
      chk("t2_data", bus.parallel_out_o, 8'hA5);
      chk("t2_sv_after", bus.serial_valid_o, 0);
      @(posedge clk); #1;
      bus.ready_in_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_in_i = 1'b0;
      @(negedge clk);
      chk("t2_vout_clr", bus.valid_out_o, 0);

      // Fill with back-pressure: 0x00..0x11 accepted, 0x12 refused
      @(posedge clk); #1;
      n = 0;
      bus.valid_in_i    = 1'b1;
      bus.parallel_in_i = 8'h00;
      for (cyc = 0; cyc < 200 && n < 18; cyc++) begin
         acc_now = bus.ready_out_o;
         @(posedge clk); #1;
         if (acc_now) begin
            n++;
            bus.parallel_in_i = 8'(n);
         end
      end
      chk("t3_accepted", n, 18);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_refused", bus.ready_out_o, 0);
      end
      chk("t3_full", bus.fifo_full_o, 1);
      chk("t3_level", bus.fifo_level_o, 16);
      chk("t3_vout", bus.valid_out_o, 1);
      chk("t3_out0", bus.parallel_out_o, 8'h00);
      chk("t3_hold_sv", bus.serial_valid_o, 0);

      // Release; HOLD pops the full FIFO while 0x12 is still offered
      @(posedge clk); #1;
      bus.ready_in_i = 1'b1;
      @(negedge clk);
      chk("t3_order", bus.parallel_out_o, 8'h00);
      @(posedge clk);
      @(negedge clk);
      chk("t4_level_pop", bus.fifo_level_o, 15);
      chk("t4_ready", bus.ready_out_o, 1);
      chk("t3_order", bus.parallel_out_o, 8'h01);
      chk("t3_vout_reload", bus.valid_out_o, 1);
      @(posedge clk); #1;
      bus.valid_in_i = 1'b0;
      @(negedge clk);
      chk("t4_level_push", bus.fifo_level_o, 16);
      chk("t4_full", bus.fifo_full_o, 1);
      exp_idx = 2;
      for (cyc = 0; cyc < 400 && exp_idx < 19; cyc++) begin
         @(negedge clk);
         if (bus.valid_out_o && bus.ready_in_i) begin
            chk("t3_order", bus.parallel_out_o, 32'(exp_idx));
            exp_idx++;
         end
      end
      chk("t3_count", exp_idx, 19);

      // Reset during SHIFT with five words queued
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         bus.valid_in_i    = 1'b1;
         bus.parallel_in_i = 8'(8'h11 * (k + 1));
         @(posedge clk); #1;
      end
      bus.valid_in_i = 1'b0;
      @(negedge clk);
      chk("t6_level_pre", bus.fifo_level_o, 5);
      chk("t6_sv_pre", bus.serial_valid_o, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_vout", bus.valid_out_o, 0);
      chk("t6_sv", bus.serial_valid_o, 0);
      chk("t6_empty", bus.fifo_empty_o, 1);
      chk("t6_level", bus.fifo_level_o, 0);
      chk("t6_ready_rst", bus.ready_out_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.valid_in_i    = 1'b1;
      bus.parallel_in_i = 8'h3C;
      @(posedge clk); #1;
      bus.valid_in_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.valid_out_o && bus.ready_in_i) begin
            cnt++;
            chk("t6_word", bus.parallel_out_o, 8'h3C);
         end
      end
      chk("t6_count", cnt, 1);
      bus.ready_in_i = 1'b0;

      // Multi-lane random sweep
      sweep_go = 1'b1;
      all_done = 1'b0;
      for (cyc = 0; cyc < 25000 && !all_done; cyc++) begin
         @(posedge clk);
         all_done = 1'b1;
         for (int i = 0; i < NSW; i++) if (!sw_done[i]) all_done = 1'b0;
      end
      chk("sw_done", all_done, 1);
      for (int i = 0; i < NSW; i++) begin
         chk($sformatf("sw%0d_bad", i), sw_bad[i], 0);
         chk($sformatf("sw%0d_words", i), sw_rcv[i], NW);
         chk($sformatf("sw%0d_serial_words", i), sw_srcv[i], NW);
         chk($sformatf("sw%0d_beats", i), sw_beats[i], NW * (8 / lanes_of(i)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
